// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types and helpers for the bit-serial subtractor.
//   state_e   : controller states (IDLE, RUN, DONE), 2-bit encoding
//   cnt_width : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_sub_cell.sv
// -----------------------------------------------------------------------------
// sub_cell
// Combinational 1-bit full subtractor: x - y - bi.
// Ports:
//   x    in  : minuend bit
//   y    in  : subtrahend bit
//   bi   in  : borrow in
//   diff out : difference bit
//   bo   out : borrow out
// -----------------------------------------------------------------------------
module sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule : sub_cell

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing d = (a - b - bin) mod 2^WIDTH,
// LSB first, one bit per clock, using a single sub_cell and a borrow flop.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds signed-overflow output ovf).
// Ports:
//   clk   in  : rising-edge clock
//   rst_n in  : asynchronous active-low reset
//   start in  : operation request, sampled only in IDLE
//   a     in  : minuend, captured when start is accepted
//   b     in  : subtrahend, captured when start is accepted
//   bin   in  : borrow-in, captured when start is accepted
//   busy  out : high while the operation is running
//   done  out : one-cycle pulse, result valid
//   d     out : registered difference, held between operations
//   bout  out : registered final borrow-out (1 iff a < b + bin)
//   ovf   out : (SERIAL_SUB_OVF_EN only) two's-complement overflow
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cell_diff_s;
  logic               cell_bo_s;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  sub_cell u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bi   (borrow_q),
    .diff (cell_diff_s),
    .bo   (cell_bo_s)
  );

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
        res_d    = {cell_diff_s, res_q[WIDTH-1:1]};
        borrow_d = cell_bo_s;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          dout_d  = {cell_diff_s, res_q[WIDTH-1:1]};
          bout_d  = cell_bo_s;
`ifdef SERIAL_SUB_OVF_EN
          // Signed overflow: borrow into the MSB differs from borrow out of it.
          ovf_d   = borrow_q ^ cell_bo_s;
`endif
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = dout_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor: an 8-bit and a 4-bit instance
// checked against a plain-arithmetic model of (a - b - bin).
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, d8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, d4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Reference: true integer difference, reduced modulo 2^w; borrow iff negative.
  function automatic void ref_sub(input int w, input int av, input int bv, input int binv,
                                  output int dv, output bit bo);
    int t;
    t  = av - bv - binv;
    bo = (t < 0);
    dv = (t + (1 << w)) % (1 << w);
  endfunction

  // Run one op on the 8-bit DUT; returns cycles to done, busy cycles, hold violations.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                     output int lat, output int busy_cnt, output int held_bad);
    int         guard;
    logic [7:0] pd;
    logic       pb;
    guard = 0;
    while ((busy8 || done8) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    pd = d8; pb = bout8;
    lat = 0; busy_cnt = 0; held_bad = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      if (d8 !== pd || bout8 !== pb) held_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Same as op8 for the 4-bit DUT (latency only).
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic binv,
                     output int lat);
    int guard;
    guard = 0;
    while ((busy4 || done4) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    a4 = av; b4 = bv; bin4 = binv; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, d8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b d=%h bout=%b want all 0", busy8, done8, d8, bout8);
    end
    checks++;
    if ({busy4, done4, d4, bout4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4: got busy=%b done=%b d=%h bout=%b want all 0", busy4, done4, d4, bout4);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [16:0] vec [5];
    int lat, bc, hb, ed;
    bit eb;
    vec[0] = {8'h35, 8'h12, 1'b0};
    vec[1] = {8'h12, 8'h35, 1'b0};
    vec[2] = {8'h00, 8'h00, 1'b1};
    vec[3] = {8'hA5, 8'hA5, 1'b0};
    vec[4] = {8'hFF, 8'h01, 1'b1};
    for (int i = 0; i < 5; i++) begin
      op8(vec[i][16:9], vec[i][8:1], vec[i][0], lat, bc, hb);
      ref_sub(8, int'(vec[i][16:9]), int'(vec[i][8:1]), int'(vec[i][0]), ed, eb);
      checks++;
      if (lat != 8 || bc != 8 || hb != 0) begin
        errors++;
        $display("FAIL basic_timing[%0d]: got lat=%0d busy=%0d holdbad=%0d want 8 8 0", i, lat, bc, hb);
      end
      checks++;
      if (d8 !== 8'(ed) || bout8 !== eb) begin
        errors++;
        $display("FAIL basic_result[%0d]: got d=%h bout=%b want d=%h bout=%b", i, d8, bout8, 8'(ed), eb);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || d8 !== 8'(ed)) begin
        errors++;
        $display("FAIL basic_pulse[%0d]: got done=%b d=%h want done=0 d=%h", i, done8, d8, 8'(ed));
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [7:0] dseen;
    pulses = 0; dseen = 8'h00;
    @(negedge clk);
    a8 = 8'h50; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) start8 = 1'b0;
      if (done8) begin
        pulses++;
        dseen = d8;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1 || dseen !== 8'h40 || bout8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got pulses=%0d d=%h bout=%b want 1 40 0", pulses, dseen, bout8);
    end
  endtask

  task automatic test_midrun_reset();
    int bad;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, d8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b d=%h bout=%b want all 0", busy8, done8, d8, bout8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8 || done8 || d8 !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_random8();
    logic [7:0] av, bv;
    logic binv;
    int lat, bc, hb, ed, bad;
    bit eb;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      av = 8'($urandom); bv = 8'($urandom); binv = 1'($urandom);
      op8(av, bv, binv, lat, bc, hb);
      ref_sub(8, int'(av), int'(bv), int'(binv), ed, eb);
      checks++;
      if (d8 !== 8'(ed) || bout8 !== eb || lat != 8 || hb != 0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL random8: a=%h b=%h bin=%b got d=%h bout=%b lat=%0d want d=%h bout=%b lat=8",
                   av, bv, binv, d8, bout8, lat, 8'(ed), eb);
      end
    end
  endtask

  task automatic test_exhaustive4();
    int lat, ed, bad;
    bit eb;
    bad = 0;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          op4(4'(av), 4'(bv), 1'(bi), lat);
          ref_sub(4, av, bv, bi, ed, eb);
          checks++;
          if (d4 !== 4'(ed) || bout4 !== eb || lat != 4) begin
            errors++;
            bad++;
            if (bad < 5)
              $display("FAIL exhaustive4: a=%h b=%h bin=%0d got d=%h bout=%b lat=%0d want d=%h bout=%b lat=4",
                       av, bv, bi, d4, bout4, lat, 4'(ed), eb);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, hb;
    time tprev, tnow;
    op8(8'h11, 8'h22, 1'b0, lat, bc, hb);
    tprev = $time;
    for (int i = 0; i < 4; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), lat, bc, hb);
      tnow = $time;
      checks++;
      if (tnow - tprev != 100) begin
        errors++;
        $display("FAIL done_spacing[%0d]: got %0t want 100", i, tnow - tprev);
      end
      tprev = tnow;
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [16:0] vec [3];
    logic [8:0]  exp [3];
    int lat, bc, hb;
    vec[0] = {8'h80, 8'h01, 1'b0}; exp[0] = {8'h7F, 1'b1};
    vec[1] = {8'h7F, 8'hFF, 1'b0}; exp[1] = {8'h80, 1'b1};
    vec[2] = {8'h05, 8'h03, 1'b0}; exp[2] = {8'h02, 1'b0};
    for (int i = 0; i < 3; i++) begin
      op8(vec[i][16:9], vec[i][8:1], vec[i][0], lat, bc, hb);
      checks++;
      if ({d8, ovf8} !== exp[i]) begin
        errors++;
        $display("FAIL ovf[%0d]: got d=%h ovf=%b want d=%h ovf=%b", i, d8, ovf8, exp[i][8:1], exp[i][0]);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_midrun_reset();
    test_random8();
    test_exhaustive4();
    test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
